ram_handshake_param: RTL
========================

Name: ram_handshake_param

Overview:
- Parametrised byte-addressed RAM with an MFA/MFC handshake and a configurable wait-state count.
- Next generation of the datapath's 512x8 memory: same byte/halfword/word access model, now with configurable address width, latency and abort behaviour.
- Sits between the control unit (MFA, RW, dataSize) and the trap-mux address / MDR data paths.
- Big-endian: lowest address holds the most-significant byte.

Parameters:
ADDR_WIDTH, 9, byte-address width; depth = 2**ADDR_WIDTH bytes
WAIT_CYCLES, 2, extra wait states between request latch and access (0..15)
CNT_WIDTH, 4, width of wait counter; must hold WAIT_CYCLES

Ports:
Clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
mfa  in  1  memory function active (request), level-held by CU
rw  in  1  1 = read, 0 = write
address  in  ADDR_WIDTH  byte address of first byte
dataIn  in  32  write data, right-justified
dataSize  in  2  00 byte, 01 halfword, 10 word, 11 reserved
dataOut  out  32  read data, zero-extended, right-justified
mfc  out  1  memory function complete
err  out  1  access rejected (only driven with ALIGN_CHECK_EN)

Behaviour:
- Reset (async, any state):
  - state = IDLE; mfc = 0; dataOut = 0; err = 0; wait counter = 0.
  - Memory array is not cleared.
  - A pending write is aborted; no byte is changed.
- States IDLE, WAIT, DONE.
- IDLE:
  - On an edge with mfa = 1: latch address, rw, dataSize and dataIn; load counter = WAIT_CYCLES; go to WAIT.
  - mfc = 0.
- WAIT:
  - mfa = 0 at an edge: abort, go to IDLE, no access, dataOut unchanged.
  - counter != 0: decrement.
  - counter == 0: perform the access atomically on this edge, set mfc = 1, go to DONE.
- Latency: mfc rises on edge N+WAIT_CYCLES+1, where N is the latch edge. With WAIT_CYCLES = 0, mfc rises on edge N+1.
- Read:
  - byte: dataOut = {24'b0, M[a]}.
  - halfword: dataOut = {16'b0, M[a], M[a+1]}.
  - word: dataOut = {M[a], M[a+1], M[a+2], M[a+3]}.
- Write:
  - byte: M[a] = dataIn[7:0].
  - halfword: M[a] = dataIn[15:8], M[a+1] = dataIn[7:0].
  - word: M[a..a+3] = dataIn[31:0], MSB first.
  - dataOut is unchanged on writes.
- Address arithmetic a+k is modulo 2**ADDR_WIDTH; accesses wrap past the top address.
- dataSize = 11 without ALIGN_CHECK_EN: treated as word.
- DONE:
  - mfc and dataOut held while mfa = 1.
  - First edge with mfa = 0: go to IDLE, mfc = 0.
  - A new request needs mfa low for at least one edge (no back-to-back on a held mfa).
- Input changes after the latch edge are ignored for the rest of the transaction.

Optional Feature:
- ALIGN_CHECK_EN defined:
  - A latched request is rejected when it is one of: halfword with address[0] = 1; word with address[1:0] != 0; dataSize = 11.
  - Rejected request: full wait latency still applies; no memory change; dataOut unchanged; mfc = 1 and err = 1 in DONE.
  - err clears when leaving DONE or on reset.
- Not defined: err tied 0, unaligned accesses proceed per the wrap rules above.

Test Plan:
- WAIT_CYCLES = 2: write word 0xDEADBEEF @0x010, then read word @0x010 -> mfc high exactly 3 edges after latch; dataOut = 0xDEADBEEF; read byte @0x011 -> 0x000000AD.
- Halfword write 0x1234 @0x020, byte reads @0x020/@0x021 -> 0x00000012 and 0x00000034; mfc drops 1 edge after mfa low.
- Word write 0xA1B2C3D4 @0x1FE (ADDR_WIDTH = 9), byte read @0x000 -> 0x000000C3 (wrap); with ALIGN_CHECK_EN the same write gives err = 1 and memory unchanged.
- Drop mfa one edge after latch of write 0xFFFFFFFF @0x040 -> FSM returns to IDLE, no mfc; subsequent read @0x040 returns the prior contents.
- Assert reset mid-WAIT of write @0x050 -> mfc = 0, dataOut = 0 immediately (async); @0x050 unchanged after reset release.
- WAIT_CYCLES = 0 build: read latency = 1 edge; mfa held high after DONE produces no second access (dataOut stable, single mfc pulse train).

Source files
------------

// File: rtl/ram_handshake_param.sv
// Byte-addressed big-endian RAM behind an MFA/MFC handshake with WAIT_CYCLES wait states.
// Optional build macro ALIGN_CHECK_EN: reject misaligned/reserved-size requests and flag them on err.
module ram_handshake_param #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  mfa,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           dataIn,
  input  logic [1:0]            dataSize,
  output logic [31:0]           dataOut,
  output logic                  mfc,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  logic [7:0]            mem [DEPTH];

  state_t                state_r, state_s;
  logic [CNT_WIDTH-1:0]  cnt_r, cnt_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  rw_r;
  logic [1:0]            size_r;
  logic [31:0]           din_r;
  logic [31:0]           dout_r, dout_s;
  logic                  mfc_r, mfc_s;
  logic                  err_r, err_s;
  logic                  latch_s;
  logic                  rej_s;
  logic [3:0]            we_s;
  logic [3:0]            wmask_s;
  logic [31:0]           rdata_s;
  logic [ADDR_WIDTH-1:0] ba_s [4];
  logic [7:0]            rb_s [4];
  logic [7:0]            wb_s [4];

  // Byte lane addresses (wrapping), read bytes, and size-dependent read/write shaping.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ba_s[k] = addr_r + ADDR_WIDTH'(k);
      rb_s[k] = mem[ba_s[k]];
    end
    rdata_s = 32'h0000_0000;
    wmask_s = 4'b0000;
    wb_s[0] = 8'h00;
    wb_s[1] = 8'h00;
    wb_s[2] = 8'h00;
    wb_s[3] = 8'h00;
    case (size_r)
      2'b00: begin
        rdata_s = {24'h000000, rb_s[0]};
        wmask_s = 4'b0001;
        wb_s[0] = din_r[7:0];
      end
      2'b01: begin
        rdata_s = {16'h0000, rb_s[0], rb_s[1]};
        wmask_s = 4'b0011;
        wb_s[0] = din_r[15:8];
        wb_s[1] = din_r[7:0];
      end
      default: begin
        // Reserved size 2'b11 falls through to a word access.
        rdata_s = {rb_s[0], rb_s[1], rb_s[2], rb_s[3]};
        wmask_s = 4'b1111;
        wb_s[0] = din_r[31:24];
        wb_s[1] = din_r[23:16];
        wb_s[2] = din_r[15:8];
        wb_s[3] = din_r[7:0];
      end
    endcase
  end

  // Rejection decision for the latched request.
  always_comb begin
`ifdef ALIGN_CHECK_EN
    if ((size_r == 2'b01 && addr_r[0]) ||
        (size_r == 2'b10 && addr_r[1:0] != 2'b00) ||
        (size_r == 2'b11)) begin
      rej_s = 1'b1;
    end else begin
      rej_s = 1'b0;
    end
`else
    rej_s = 1'b0;
`endif
  end

  // Handshake FSM next-state and output logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    dout_s  = dout_r;
    mfc_s   = mfc_r;
    err_s   = err_r;
    latch_s = 1'b0;
    we_s    = 4'b0000;
    case (state_r)
      ST_IDLE: begin
        mfc_s = 1'b0;
        err_s = 1'b0;
        if (mfa) begin
          latch_s = 1'b1;
          cnt_s   = CNT_WIDTH'(WAIT_CYCLES);
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!mfa) begin
          state_s = ST_IDLE;
        end else if (cnt_r != {CNT_WIDTH{1'b0}}) begin
          cnt_s = cnt_r - CNT_WIDTH'(1);
        end else begin
          // Access happens atomically on this edge.
          state_s = ST_DONE;
          mfc_s   = 1'b1;
          err_s   = rej_s;
          if (rej_s) begin
            we_s = 4'b0000;
          end else if (rw_r) begin
            dout_s = rdata_s;
          end else begin
            we_s = wmask_s;
          end
        end
      end
      ST_DONE: begin
        if (!mfa) begin
          state_s = ST_IDLE;
          mfc_s   = 1'b0;
          err_s   = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        mfc_s   = 1'b0;
        err_s   = 1'b0;
      end
    endcase
  end

  // Control/request/output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_WIDTH{1'b0}};
      addr_r  <= {ADDR_WIDTH{1'b0}};
      rw_r    <= 1'b0;
      size_r  <= 2'b00;
      din_r   <= 32'h0000_0000;
      dout_r  <= 32'h0000_0000;
      mfc_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      dout_r  <= dout_s;
      mfc_r   <= mfc_s;
      err_r   <= err_s;
      if (latch_s) begin
        addr_r <= address;
        rw_r   <= rw;
        size_r <= dataSize;
        din_r  <= dataIn;
      end
    end
  end

  // Byte-lane array writes; reset forces IDLE asynchronously so no lane is enabled.
  always_ff @(posedge Clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we_s[k]) begin
        mem[ba_s[k]] <= wb_s[k];
      end
    end
  end

  assign dataOut = dout_r;
  assign mfc     = mfc_r;
  assign err     = err_r;

endmodule
